// File: rtl/synth_pkg.sv
// Shared definitions for the polyphonic ADSR synthesizer: envelope state
// encoding and the guard width used by the saturating envelope arithmetic.
package synth_pkg;

  typedef logic [2:0] env_state_t;

  localparam env_state_t ST_IDLE    = 3'd0;
  localparam env_state_t ST_ATTACK  = 3'd1;
  localparam env_state_t ST_DECAY   = 3'd2;
  localparam env_state_t ST_SUSTAIN = 3'd3;
  localparam env_state_t ST_RELEASE = 3'd4;

  // Extra MSBs carried through env +/- step so carry/borrow is visible.
  localparam int unsigned SAT_GUARD_W = 1;

endpackage

// File: rtl/adsr_voice.sv
// One synth voice: phase accumulator, ADSR envelope FSM and the scaled
// unsigned sample. All state advances only on sample ticks.
module adsr_voice
  import synth_pkg::*;
#(
  parameter int unsigned PW    = 16,
  parameter int unsigned AW    = 6,
  parameter int unsigned ENV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic             key_i,
  input  logic [PW-1:0]    inc_i,
  input  logic [ENV_W-1:0] attack_step_i,
  input  logic [ENV_W-1:0] decay_step_i,
  input  logic [ENV_W-1:0] sustain_lvl_i,
  input  logic [ENV_W-1:0] release_step_i,
  output logic             active_o,
  output logic [AW-1:0]    sample_o
);

  localparam int unsigned XW = ENV_W + SAT_GUARD_W;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  env_state_t          state_q, state_d;
  logic [ENV_W-1:0]    env_q, env_d;
  logic [PW-1:0]       phase_q;
  logic                key_q;
  logic                rise;
  logic [XW-1:0]       add_x, rel_x, dec_x;
  logic [ENV_W-1:0]    env_up, env_rel, dec_floor, env_dec;
  logic [AW+ENV_W-1:0] prod;

  assign add_x     = XW'(env_q) + XW'(attack_step_i);
  assign rel_x     = XW'(env_q) - XW'(release_step_i);
  assign dec_x     = XW'(env_q) - XW'(decay_step_i);
  assign env_up    = (|add_x[XW-1:ENV_W]) ? ENV_MAX : add_x[ENV_W-1:0];
  assign env_rel   = rel_x[XW-1] ? '0 : rel_x[ENV_W-1:0];
  assign dec_floor = dec_x[XW-1] ? '0 : dec_x[ENV_W-1:0];
  assign env_dec   = (dec_floor < sustain_lvl_i) ? sustain_lvl_i : dec_floor;
  assign rise      = key_i & ~key_q;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          env_d   = env_up;
          state_d = (env_up == ENV_MAX) ? ST_DECAY : ST_ATTACK;
        end
      end
      ST_ATTACK, ST_DECAY, ST_SUSTAIN: begin
        if (!key_i) begin
          env_d   = env_rel;
          state_d = (env_rel == '0) ? ST_IDLE : ST_RELEASE;
        end else if (state_q == ST_ATTACK) begin
          env_d = env_up;
          if (env_up == ENV_MAX) state_d = ST_DECAY;
        end else if (state_q == ST_DECAY) begin
          env_d = env_dec;
          if (env_dec == sustain_lvl_i) state_d = ST_SUSTAIN;
        end else begin
          env_d = sustain_lvl_i;
        end
      end
      ST_RELEASE: begin
        // Retrigger keeps the current level; attack ramps from it next tick.
        if (rise) begin
          state_d = ST_ATTACK;
        end else begin
          env_d = env_rel;
          if (env_rel == '0) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        env_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !en_i) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      phase_q <= '0;
      key_q   <= 1'b0;
    end else if (tick_i) begin
      state_q <= state_d;
      env_q   <= env_d;
      phase_q <= phase_q + inc_i;
      key_q   <= key_i;
    end
  end

  assign prod     = (AW+ENV_W)'(phase_q[PW-1 -: AW]) * (AW+ENV_W)'(env_q);
  assign sample_o = AW'(prod >> ENV_W);
  assign active_o = (state_q != ST_IDLE);

endmodule

// File: rtl/poly_adsr_synth.sv
// Polyphonic ADSR synthesizer: sample-rate divider, NVOICE voices, a
// saturating mixer and a PWM audio output stage.
module poly_adsr_synth
  import synth_pkg::*;
#(
  parameter int unsigned NVOICE     = 12,
  parameter int unsigned PW         = 16,
  parameter int unsigned AW         = 6,
  parameter int unsigned ENV_W      = 8,
  parameter int unsigned SAMPLE_DIV = 1600,
  parameter int unsigned MIX_SHIFT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NVOICE-1:0]    key,
  input  logic [NVOICE*PW-1:0] inc,
  input  logic [ENV_W-1:0]     attack_step,
  input  logic [ENV_W-1:0]     decay_step,
  input  logic [ENV_W-1:0]     sustain_lvl,
  input  logic [ENV_W-1:0]     release_step,
  output logic                 sample_tick,
  output logic [NVOICE-1:0]    active,
  output logic [AW-1:0]        mix,
  output logic                 pwm_out
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned SUM_W = AW + $clog2(NVOICE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [AW-1:0] AMP_MAX = '1;

  logic [DIV_W-1:0] div_q;
  logic             tick, tick_q;
  logic [AW-1:0]    sample_w [NVOICE];
  logic [SUM_W-1:0] voice_sum, mix_shifted;
  logic [AW-1:0]    mix_d, mix_q, duty_q, pwm_cnt_q;
  logic             pwm_q;

  assign tick = en && (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset || !en || tick) div_q <= '0;
    else                      div_q <= div_q + 1'b1;
  end

  for (genvar i = 0; i < NVOICE; i++) begin : g_voice
    adsr_voice #(
      .PW   (PW),
      .AW   (AW),
      .ENV_W(ENV_W)
    ) u_voice (
      .clk           (clk),
      .reset         (reset),
      .en_i          (en),
      .tick_i        (tick),
      .key_i         (key[i]),
      .inc_i         (inc[i*PW +: PW]),
      .attack_step_i (attack_step),
      .decay_step_i  (decay_step),
      .sustain_lvl_i (sustain_lvl),
      .release_step_i(release_step),
      .active_o      (active[i]),
      .sample_o      (sample_w[i])
    );
  end

  always_comb begin
    voice_sum = '0;
    for (int unsigned i = 0; i < NVOICE; i++) begin
      voice_sum = voice_sum + SUM_W'(sample_w[i]);
    end
  end

  assign mix_shifted = voice_sum >> MIX_SHIFT;
  assign mix_d = (mix_shifted > SUM_W'(AMP_MAX)) ? AMP_MAX : mix_shifted[AW-1:0];

  // Voices settle on the tick edge, so the mixer captures one clk later.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      tick_q <= 1'b0;
      mix_q  <= '0;
    end else begin
      tick_q <= tick;
      if (tick_q) mix_q <= mix_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (pwm_cnt_q == AMP_MAX) duty_q <= mix_q;
      pwm_q <= (pwm_cnt_q < duty_q);
    end
  end

  assign sample_tick = tick;
  assign mix         = mix_q;
  assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_poly_adsr_synth.sv
// Randomized self-checking bench for poly_adsr_synth against a tick-level
// behavioural model of voices, envelopes, phase and mixing.
`timescale 1ns/1ps
module tb_poly_adsr_synth;
  import synth_pkg::*;

  localparam int NV  = 2;
  localparam int PW  = 16;
  localparam int AW  = 6;
  localparam int EW  = 8;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          reset, en;
  logic [NV-1:0] key;
  logic [NV*PW-1:0] inc;
  logic [EW-1:0] attack_step, decay_step, sustain_lvl, release_step;
  logic          sample_tick;
  logic [NV-1:0] active;
  logic [AW-1:0] mix;
  logic          pwm_out;

  always #5 clk = ~clk;

  poly_adsr_synth #(
    .NVOICE    (NV),
    .PW        (PW),
    .AW        (AW),
    .ENV_W     (EW),
    .SAMPLE_DIV(DIV),
    .MIX_SHIFT (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .key         (key),
    .inc         (inc),
    .attack_step (attack_step),
    .decay_step  (decay_step),
    .sustain_lvl (sustain_lvl),
    .release_step(release_step),
    .sample_tick (sample_tick),
    .active      (active),
    .mix         (mix),
    .pwm_out     (pwm_out)
  );

  typedef enum int {M_IDLE, M_ATTACK, M_DECAY, M_SUSTAIN, M_RELEASE} mstate_e;
  mstate_e m_st    [NV];
  int      m_env   [NV];
  int      m_phase [NV];
  bit      m_keyq  [NV];
  int      m_mix;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_tick_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dut_env(input int v);
    return (v == 0) ? int'(dut.g_voice[0].u_voice.env_q) : int'(dut.g_voice[1].u_voice.env_q);
  endfunction

  function automatic int dut_phase(input int v);
    return (v == 0) ? int'(dut.g_voice[0].u_voice.phase_q) : int'(dut.g_voice[1].u_voice.phase_q);
  endfunction

  function automatic int dut_state(input int v);
    return (v == 0) ? int'(dut.g_voice[0].u_voice.state_q) : int'(dut.g_voice[1].u_voice.state_q);
  endfunction

  function automatic int m2pkg(input mstate_e s);
    case (s)
      M_ATTACK:  return int'(ST_ATTACK);
      M_DECAY:   return int'(ST_DECAY);
      M_SUSTAIN: return int'(ST_SUSTAIN);
      M_RELEASE: return int'(ST_RELEASE);
      default:   return int'(ST_IDLE);
    endcase
  endfunction

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_st[v] = M_IDLE; m_env[v] = 0; m_phase[v] = 0; m_keyq[v] = 1'b0;
    end
    m_mix = 0;
    last_tick_cyc = -1;
  endtask

  task automatic model_tick();
    int sum, e, up, rl, dc, sus;
    bit k, rise;
    sum = 0;
    sus = int'(sustain_lvl);
    for (int v = 0; v < NV; v++) begin
      e    = m_env[v];
      up   = (e + int'(attack_step) > 255) ? 255 : e + int'(attack_step);
      rl   = (e - int'(release_step) < 0) ? 0 : e - int'(release_step);
      dc   = (e - int'(decay_step) < sus) ? sus : e - int'(decay_step);
      k    = key[v];
      rise = k && !m_keyq[v];
      case (m_st[v])
        M_IDLE: if (rise) begin
          e = up;
          m_st[v] = (up == 255) ? M_DECAY : M_ATTACK;
        end
        M_RELEASE: if (rise) m_st[v] = M_ATTACK;
                   else begin e = rl; if (rl == 0) m_st[v] = M_IDLE; end
        default: if (!k) begin
          e = rl;
          m_st[v] = (rl == 0) ? M_IDLE : M_RELEASE;
        end else if (m_st[v] == M_ATTACK) begin
          e = up; if (up == 255) m_st[v] = M_DECAY;
        end else if (m_st[v] == M_DECAY) begin
          e = dc; if (dc == sus) m_st[v] = M_SUSTAIN;
        end else e = sus;
      endcase
      m_env[v]   = e;
      m_keyq[v]  = k;
      m_phase[v] = (m_phase[v] + int'(inc[v*PW +: PW])) % 65536;
      sum += ((m_phase[v] / 1024) * m_env[v]) / 256;
    end
    m_mix = (sum > 63) ? 63 : sum;
  endtask

  task automatic check_voices(input string tag);
    for (int v = 0; v < NV; v++) begin
      check_eq($sformatf("%s_env%0d", tag, v), dut_env(v), m_env[v]);
      check_eq($sformatf("%s_phase%0d", tag, v), dut_phase(v), m_phase[v]);
      check_eq($sformatf("%s_state%0d", tag, v), dut_state(v), m2pkg(m_st[v]));
      check_eq($sformatf("%s_active%0d", tag, v), int'(active[v]), (m_st[v] != M_IDLE) ? 1 : 0);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after mix has been refreshed.
  task automatic do_tick(input string tag);
    int waited = 0;
    @(negedge clk);
    while (!sample_tick && waited < 3*DIV) begin
      @(negedge clk);
      waited++;
    end
    if (!sample_tick) begin
      check_eq({tag, "_tick_timeout"}, int'(sample_tick), 1);
      return;
    end
    if (last_tick_cyc >= 0) check_eq({tag, "_tick_gap"}, cyc - last_tick_cyc, DIV);
    last_tick_cyc = cyc;
    model_tick();
    @(posedge clk); #1;
    check_voices(tag);
    check_eq({tag, "_tick_width"}, int'(sample_tick), 0);
    @(posedge clk); #1;
    check_eq({tag, "_mix"}, int'(mix), m_mix);
  endtask

  task automatic drop_en();
    en = 1'b0;
    @(posedge clk); #1;
    model_clear();
  endtask

  task automatic count_pwm(output int highs);
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=no_finish expected=finish");
    $fatal(1);
  end

  initial begin
    int env_tab [8];
    int ph_tab  [4];
    int highs, ticks_seen;
    env_tab = '{64, 128, 192, 255, 223, 191, 159, 128};
    ph_tab  = '{16'h4000, 16'h8000, 16'hC000, 0};

    reset = 1'b1; en = 1'b1; key = 2'b11; inc = '0;
    attack_step = '0; decay_step = '0; sustain_lvl = '0; release_step = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tick", int'(sample_tick), 0);
    check_eq("rst_active", int'(active), 0);
    check_eq("rst_mix", int'(mix), 0);
    check_eq("rst_pwm", int'(pwm_out), 0);
    check_voices("rst");

    // Attack / decay / sustain on voice 0 with phase wrap.
    key = 2'b01; inc = {16'h0000, 16'h4000};
    attack_step = 8'd64; decay_step = 8'd32; sustain_lvl = 8'd128; release_step = 8'd255;
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      do_tick($sformatf("adsr%0d", t));
      check_eq($sformatf("adsr_tab%0d", t), dut_env(0), env_tab[t]);
      if (t < 4) check_eq($sformatf("wrap_tab%0d", t), dut_phase(0), ph_tab[t]);
    end
    check_eq("sustain_state", dut_state(0), int'(ST_SUSTAIN));

    key = 2'b00;
    do_tick("release");
    check_eq("release_env", dut_env(0), 0);
    check_eq("release_state", dut_state(0), int'(ST_IDLE));
    check_eq("release_active", int'(active[0]), 0);

    // Mixer saturation: both voices at full amplitude.
    drop_en();
    en = 1'b1; key = 2'b11; inc = {16'hFC00, 16'hFC00};
    attack_step = 8'd255; decay_step = 8'd0; sustain_lvl = 8'd255;
    do_tick("sat");
    check_eq("mix_sat", int'(mix), 63);

    // PWM duty of 16/64.
    drop_en();
    en = 1'b1; key = 2'b01; inc = {16'h0000, 16'h8000};
    attack_step = 8'd255; decay_step = 8'd127; sustain_lvl = 8'd128;
    do_tick("pwm_a");
    inc = '0;
    do_tick("pwm_b");
    check_eq("pwm_mix", int'(mix), 16);
    repeat (140) @(posedge clk);
    count_pwm(highs);
    check_eq("pwm_duty16", highs, 16);

    // Disabled: no ticks, mix 0, PWM silent, voices cleared.
    drop_en();
    ticks_seen = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (sample_tick) ticks_seen++;
    end
    check_eq("dis_ticks", ticks_seen, 0);
    check_eq("dis_mix", int'(mix), 0);
    count_pwm(highs);
    check_eq("dis_pwm", highs, 0);
    check_voices("dis");

    // Randomized stretch.
    en = 1'b1;
    for (int t = 0; t < 70; t++) begin
      if ($urandom_range(0, 9) < 4) key = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        attack_step  = 8'($urandom);
        decay_step   = 8'($urandom);
        sustain_lvl  = 8'($urandom);
        release_step = 8'($urandom_range(0, 80));
        inc          = 32'($urandom);
      end
      if ($urandom_range(0, 24) == 0) begin
        drop_en();
        en = 1'b1;
      end
      do_tick($sformatf("rnd%0d", t));
    end

    // Reset mid-attack wins over en and tick.
    drop_en();
    en = 1'b1; key = 2'b11; inc = {16'h1234, 16'h0F00};
    attack_step = 8'd16;
    do_tick("pre_rst");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    check_voices("mid_rst");
    check_eq("mid_rst_mix", int'(mix), 0);
    check_eq("mid_rst_tick", int'(sample_tick), 0);
    reset = 1'b0;
    do_tick("post_rst");
    check_eq("post_rst_env0", dut_env(0), 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
